// File: rtl/conv2d_axis_bridge.sv
// conv2d_axis_bridge: AXI-Stream ingress unpacker and egress serialiser for the conv2d engine
// Ports: clk, rst_n (async assert, active-low); s_tdata/s_tvalid/s_tlast/s_tready packed ingress beats;
//   pix_data/pix_valid/pix_ready one pixel per cycle to the line buffer; res_data/res_valid/res_ready
//   result vectors from the datapath; m_tdata/m_tvalid/m_tlast/m_tready egress beats;
//   frame_err sticky flag for s_tlast not landing on a frame boundary.
module conv2d_axis_bridge #(
  parameter int IN_W          = 64,
  parameter int PIXEL_W       = 16,
  parameter int RES_W         = 128,
  parameter int OUT_W         = 64,
  parameter int FRAME_PIXELS  = 1024,
  parameter int FRAME_RESULTS = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_W-1:0]    s_tdata,
  input  logic               s_tvalid,
  input  logic               s_tlast,
  output logic               s_tready,
  output logic [PIXEL_W-1:0] pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  input  logic [RES_W-1:0]   res_data,
  input  logic               res_valid,
  output logic               res_ready,
  output logic [OUT_W-1:0]   m_tdata,
  output logic               m_tvalid,
  output logic               m_tlast,
  input  logic               m_tready,
  output logic               frame_err
);
  localparam int PPB = IN_W / PIXEL_W;
  localparam int BPR = RES_W / OUT_W;
  localparam int PIW = PPB > 1 ? $clog2(PPB) : 1;
  localparam int BIW = BPR > 1 ? $clog2(BPR) : 1;
  localparam int PCW = $clog2(FRAME_PIXELS + 1);
  localparam int RCW = FRAME_RESULTS > 1 ? $clog2(FRAME_RESULTS) : 1;
  typedef enum logic {P_EMPTY, P_UNPACK} p_state_t;
  typedef enum logic {M_EMPTY, M_SEND} m_state_t;
  p_state_t                    p_st;
  m_state_t                    m_st;
  logic [PPB-1:0][PIXEL_W-1:0] hold;
  logic [BPR-1:0][OUT_W-1:0]   ser;
  logic [PIW-1:0]              p_idx;
  logic [BIW-1:0]              b_idx;
  logic [PCW-1:0]              pix_cnt;
  logic [RCW-1:0]              r_cnt;
  logic                        p_last, b_last, beat_end, s_hs, p_hs, r_hs, m_hs;
  assign p_last    = p_idx == PIW'(PPB - 1);
  assign b_last    = b_idx == BIW'(BPR - 1);
  // pix_cnt is the frame index of the first pixel in the incoming beat
  assign beat_end  = pix_cnt == PCW'(FRAME_PIXELS - PPB);
  assign pix_valid = p_st == P_UNPACK;
  assign m_tvalid  = m_st == M_SEND;
  assign s_tready  = !pix_valid || (p_last && pix_ready);
  assign res_ready = !m_tvalid || (b_last && m_tready);
  assign pix_data  = hold[p_idx];
  assign m_tdata   = ser[b_idx];
  assign m_tlast   = m_tvalid && b_last && r_cnt == RCW'(FRAME_RESULTS - 1);
  assign s_hs      = s_tvalid && s_tready;
  assign p_hs      = pix_valid && pix_ready;
  assign r_hs      = res_valid && res_ready;
  assign m_hs      = m_tvalid && m_tready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_st      <= P_EMPTY;
      hold      <= '0;
      p_idx     <= '0;
      pix_cnt   <= '0;
      frame_err <= 1'b0;
    end else if (s_hs) begin
      hold      <= s_tdata;
      p_st      <= P_UNPACK;
      p_idx     <= '0;
      frame_err <= frame_err || (s_tlast != beat_end);
      pix_cnt   <= (s_tlast || beat_end) ? '0 : pix_cnt + PCW'(PPB);
    end else if (p_hs) begin
      p_st  <= p_last ? P_EMPTY : P_UNPACK;
      p_idx <= p_last ? '0 : p_idx + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_st  <= M_EMPTY;
      ser   <= '0;
      b_idx <= '0;
      r_cnt <= '0;
    end else begin
      if (r_hs) begin
        ser   <= res_data;
        m_st  <= M_SEND;
        b_idx <= '0;
      end else if (m_hs) begin
        m_st  <= b_last ? M_EMPTY : M_SEND;
        b_idx <= b_last ? '0 : b_idx + 1'b1;
      end
      if (m_hs && b_last)
        r_cnt <= r_cnt == RCW'(FRAME_RESULTS - 1) ? '0 : r_cnt + 1'b1;
    end
endmodule
